// File: rtl/ami_channel_dram_bridge_pkg.sv
// Shared AMI request/response types and constants for the channel-to-DRAM bridge.
package ami_channel_dram_bridge_pkg;

    localparam int AMI_DATA_WIDTH = 512;
    localparam int AMI_ADDR_WIDTH = 64;
    localparam int AMI_SIZE_WIDTH = 7;

    typedef struct packed {
        logic                      valid;
        logic                      isWrite;
        logic [AMI_ADDR_WIDTH-1:0] addr;
        logic [AMI_DATA_WIDTH-1:0] data;
        logic [AMI_SIZE_WIDTH-1:0] size;
    } AMIRequest;

    typedef struct packed {
        logic                      valid;
        logic [AMI_DATA_WIDTH-1:0] data;
        logic [AMI_SIZE_WIDTH-1:0] size;
    } AMIResponse;

    typedef struct packed {
        logic [AMI_DATA_WIDTH-1:0] data;
        logic [AMI_SIZE_WIDTH-1:0] size;
    } resp_entry_t;

    typedef enum logic {
        REQ_EMPTY = 1'b0,
        REQ_HELD  = 1'b1
    } req_state_e;

endpackage

// File: rtl/ami_channel_dram_bridge_resp_fifo.sv
// Synchronous response FIFO; a push is accepted when full only if a pop happens in the same cycle.
module ami_resp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 519
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; consumers gate the head with empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ami_channel_dram_bridge.sv
// Per-channel bridge: one-entry request buffer, in-order DRAM line commands,
// credit-protected read response FIFO.
//
//  state     | meaning
//  REQ_EMPTY | no request buffered, grant offered
//  REQ_HELD  | request buffered, command presented when issuable
module ami_channel_dram_bridge
    import ami_channel_dram_bridge_pkg::*;
#(
    parameter int RESP_DEPTH  = 16,
    parameter int LINE_BYTES  = 64,
    parameter int DRAM_ADDR_W = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  AMIRequest                       mem_req_in,
    output logic                            mem_req_grant_out,
    output AMIResponse                      mem_resp_out,
    input  logic                            mem_resp_grant_in,
    output logic                            dram_cmd_valid,
    input  logic                            dram_cmd_ready,
    output logic                            dram_cmd_write,
    output logic [DRAM_ADDR_W-1:0]          dram_cmd_addr,
    output logic [AMI_DATA_WIDTH-1:0]       dram_wdata,
    input  logic                            dram_rdata_valid,
    input  logic [AMI_DATA_WIDTH-1:0]       dram_rdata,
    output logic [$clog2(RESP_DEPTH):0]     rd_inflight,
    output logic                            err_size,
    output logic                            err_spurious
);

    localparam int LINE_SHIFT = $clog2(LINE_BYTES);
    localparam int CW         = $clog2(RESP_DEPTH) + 1;
    localparam logic [AMI_SIZE_WIDTH-1:0] SIZE_LINE = AMI_SIZE_WIDTH'(LINE_BYTES);
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(RESP_DEPTH);

    req_state_e  state;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_sum;
    logic          credit_ok;
    logic          issue_fire;
    logic          accept;
    logic          rd_issue;
    logic          rd_return;
    logic          fifo_empty;
    logic          fifo_full;
    resp_entry_t   fifo_head;
    resp_entry_t   fifo_in;
    logic          unused_addr_bits;

    // Credits count reads in flight plus buffered responses, so DRAM data always has a slot.
    assign credit_sum = {1'b0, rd_inflight} + {1'b0, fifo_count};
    assign credit_ok  = credit_sum < CREDIT_MAX;

    assign dram_cmd_valid    = (state == REQ_HELD) && (dram_cmd_write || credit_ok);
    assign issue_fire        = dram_cmd_valid && dram_cmd_ready;
    assign mem_req_grant_out = rst && ((state == REQ_EMPTY) || issue_fire);
    assign accept            = mem_req_in.valid && mem_req_grant_out;

    assign rd_issue  = issue_fire && !dram_cmd_write;
    assign rd_return = dram_rdata_valid && (rd_inflight != '0);

    assign unused_addr_bits = ^{mem_req_in.addr[LINE_SHIFT-1:0],
                                mem_req_in.addr[AMI_ADDR_WIDTH-1:LINE_SHIFT+DRAM_ADDR_W]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= REQ_EMPTY;
            dram_cmd_write <= 1'b0;
            dram_cmd_addr  <= '0;
            dram_wdata     <= '0;
        end else begin
            if (accept) begin
                state          <= REQ_HELD;
                dram_cmd_write <= mem_req_in.isWrite;
                dram_cmd_addr  <= mem_req_in.addr[LINE_SHIFT +: DRAM_ADDR_W];
                dram_wdata     <= mem_req_in.data;
            end else if (issue_fire) begin
                state <= REQ_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_inflight  <= '0;
            err_size     <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            case ({rd_issue, rd_return})
                2'b10:   rd_inflight <= rd_inflight + 1'b1;
                2'b01:   rd_inflight <= rd_inflight - 1'b1;
                default: rd_inflight <= rd_inflight;
            endcase
            if (accept && (mem_req_in.size != SIZE_LINE)) err_size <= 1'b1;
            if (dram_rdata_valid && (rd_inflight == '0))  err_spurious <= 1'b1;
        end
    end

    assign fifo_in.data = dram_rdata;
    assign fifo_in.size = SIZE_LINE;

    ami_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH ($bits(resp_entry_t))
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (rd_return),
        .wdata (fifo_in),
        .pop   (mem_resp_grant_in),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head is zeroed while empty so the response bus never shows stale storage.
    always_comb begin
        mem_resp_out = '0;
        if (!fifo_empty) begin
            mem_resp_out.valid = 1'b1;
            mem_resp_out.data  = fifo_head.data;
            mem_resp_out.size  = fifo_head.size;
        end
    end

    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;

endmodule

// File: tb/tb_ami_channel_dram_bridge.sv
// Directed bench for the AMI channel DRAM bridge: vector table plus multi-cycle corner sequences.
module tb_ami_channel_dram_bridge;
    import ami_channel_dram_bridge_pkg::*;

    logic         clk;
    logic         rst;
    AMIRequest    req;
    logic         grant;
    AMIResponse   resp;
    logic         resp_grant;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_write;
    logic [31:0]  cmd_addr;
    logic [511:0] wdata;
    logic         rdata_valid;
    logic [511:0] rdata;
    logic [4:0]   rd_inflight;
    logic         err_size;
    logic         err_spurious;

    int errors = 0;
    int checks = 0;

    ami_channel_dram_bridge dut (
        .clk               (clk),
        .rst               (rst),
        .mem_req_in        (req),
        .mem_req_grant_out (grant),
        .mem_resp_out      (resp),
        .mem_resp_grant_in (resp_grant),
        .dram_cmd_valid    (cmd_valid),
        .dram_cmd_ready    (cmd_ready),
        .dram_cmd_write    (cmd_write),
        .dram_cmd_addr     (cmd_addr),
        .dram_wdata        (wdata),
        .dram_rdata_valid  (rdata_valid),
        .dram_rdata        (rdata),
        .rd_inflight       (rd_inflight),
        .err_size          (err_size),
        .err_spurious      (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  addr;
        logic         wr;
        logic [6:0]   size;
        logic [511:0] data;
        logic [31:0]  exp_line;
        logic         exp_err_size;
    } vec_t;

    typedef struct {
        int          t;
        logic [31:0] a;
    } pend_t;

    function automatic logic [511:0] pat(input int k);
        return {16{32'(k)}};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input vec_t v);
        req.valid   = 1'b1;
        req.isWrite = v.wr;
        req.addr    = v.addr;
        req.data    = v.data;
        req.size    = v.size;
        #1;
        chk("txn_grant_idle", 512'(grant), 512'(1));
        tick();
        req.valid = 1'b0;
        #1;
        chk("txn_cmd_valid", 512'(cmd_valid), 512'(1));
        chk("txn_cmd_addr", 512'(cmd_addr), 512'(v.exp_line));
        chk("txn_cmd_write", 512'(cmd_write), 512'(v.wr));
        if (v.wr) chk("txn_wdata", wdata, v.data);
        tick();
        #1;
        chk("txn_cmd_done", 512'(cmd_valid), 512'(0));
        chk("txn_inflight_issue", 512'(rd_inflight), v.wr ? 512'(0) : 512'(1));
        if (!v.wr) begin
            tick();
            tick();
            rdata_valid = 1'b1;
            rdata       = v.data;
            #1;
            chk("txn_resp_early", 512'(resp.valid), 512'(0));
            tick();
            rdata_valid = 1'b0;
            #1;
            chk("txn_resp_valid", 512'(resp.valid), 512'(1));
            chk("txn_resp_data", resp.data, v.data);
            chk("txn_resp_size", 512'(resp.size), 512'(64));
            chk("txn_inflight_ret", 512'(rd_inflight), 512'(0));
            resp_grant = 1'b1;
            tick();
            resp_grant = 1'b0;
            #1;
            chk("txn_resp_popped", 512'(resp.valid), 512'(0));
        end else begin
            tick();
            #1;
            chk("txn_wr_no_resp", 512'(resp.valid), 512'(0));
        end
        chk("txn_err_size", 512'(err_size), 512'(v.exp_err_size));
    endtask

    task automatic send_read(input logic [63:0] a);
        req.valid   = 1'b1;
        req.isWrite = 1'b0;
        req.addr    = a;
        req.data    = '0;
        req.size    = 7'd64;
        #1;
        for (int i = 0; i < 50 && !grant; i++) tick();
        chk("send_grant", 512'(grant), 512'(1));
        tick();
        req.valid = 1'b0;
    endtask

    task automatic return_data(input logic [511:0] d);
        rdata_valid = 1'b1;
        rdata       = d;
        tick();
        rdata_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[6];
        vec_t  post;
        pend_t pend[$];
        int    sent;
        int    n_issued;
        int    nresp;

        tbl[0] = '{64'h1040, 1'b0, 7'd64, {8{64'h0123_4567_89AB_CDEF}}, 32'h41, 1'b0};
        tbl[1] = '{64'h0, 1'b1, 7'd64, {64{8'h3C}}, 32'h0, 1'b0};
        tbl[2] = '{64'h7F, 1'b0, 7'd64, {16{32'hCAFE_F00D}}, 32'h1, 1'b0};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 7'd64, {32{16'h55AA}}, 32'hFFFF_FFFF, 1'b0};
        tbl[4] = '{64'h12_3456_7880, 1'b1, 7'd64, {8{64'hFEDC_BA98_7654_3210}}, 32'h48D1_59E2, 1'b0};
        tbl[5] = '{64'h2A80, 1'b0, 7'd32, {16{32'h1357_9BDF}}, 32'hAA, 1'b1};
        post   = '{64'h2000, 1'b0, 7'd64, {16{32'h2468_ACE0}}, 32'h80, 1'b0};

        rst         = 1'b0;
        req         = '0;
        resp_grant  = 1'b0;
        cmd_ready   = 1'b0;
        rdata_valid = 1'b0;
        rdata       = '0;
        tick();
        tick();
        chk("rst_grant", 512'(grant), 512'(0));
        chk("rst_cmd_valid", 512'(cmd_valid), 512'(0));
        chk("rst_resp_valid", 512'(resp.valid), 512'(0));
        chk("rst_inflight", 512'(rd_inflight), 512'(0));
        chk("rst_errs", 512'({err_size, err_spurious}), 512'(0));
        rst = 1'b1;
        #1;
        chk("post_rst_grant", 512'(grant), 512'(1));

        // Table: single transactions, address mapping, size error.
        cmd_ready = 1'b1;
        for (int i = 0; i < 6; i++) do_txn(tbl[i]);

        // 20 back-to-back reads, data returns 10 cycles after issue, consumer stalled until cycle 60.
        sent = 0;
        n_issued = 0;
        nresp = 0;
        for (int cyc = 0; cyc < 400 && nresp < 20; cyc++) begin
            req.valid   = (sent < 20);
            req.isWrite = 1'b0;
            req.addr    = 64'(sent) << 6;
            req.size    = 7'd64;
            req.data    = '0;
            rdata_valid = 1'b0;
            if (pend.size() > 0) begin
                if (pend[0].t == cyc) begin
                    rdata_valid = 1'b1;
                    rdata       = {16{pend[0].a}};
                    void'(pend.pop_front());
                end
            end
            resp_grant = (cyc >= 60);
            #1;
            if (cyc == 59) begin
                chk("burst_issued_cap", 512'(n_issued), 512'(16));
                chk("burst_grant_low", 512'(grant), 512'(0));
                chk("burst_cmd_blocked", 512'(cmd_valid), 512'(0));
                chk("burst_inflight", 512'(rd_inflight), 512'(0));
            end
            if (req.valid && grant) sent++;
            if (cmd_valid && cmd_ready) begin
                pend.push_back('{cyc + 10, cmd_addr});
                n_issued++;
            end
            if (resp.valid && resp_grant) begin
                chk("burst_order", resp.data, pat(nresp));
                nresp++;
            end
            tick();
        end
        req.valid   = 1'b0;
        rdata_valid = 1'b0;
        resp_grant  = 1'b0;
        #1;
        chk("burst_nresp", 512'(nresp), 512'(20));
        chk("burst_total_issued", 512'(n_issued), 512'(20));
        chk("burst_no_spurious", 512'(err_spurious), 512'(0));
        chk("burst_drained", 512'(resp.valid), 512'(0));

        // Write stalled by controller for 5 cycles, then reload with a second write.
        cmd_ready   = 1'b0;
        req.valid   = 1'b1;
        req.isWrite = 1'b1;
        req.addr    = 64'h80;
        req.data    = {64{8'hA5}};
        req.size    = 7'd64;
        #1;
        chk("wr_grant_idle", 512'(grant), 512'(1));
        tick();
        req.addr = 64'h100;
        req.data = {64{8'h5A}};
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("wr_hold_valid", 512'(cmd_valid), 512'(1));
            chk("wr_hold_addr", 512'(cmd_addr), 512'(2));
            chk("wr_hold_write", 512'(cmd_write), 512'(1));
            chk("wr_hold_data", wdata, {64{8'hA5}});
            chk("wr_hold_grant", 512'(grant), 512'(0));
            tick();
        end
        cmd_ready = 1'b1;
        #1;
        chk("wr_grant_on_ready", 512'(grant), 512'(1));
        tick();
        req.valid = 1'b0;
        #1;
        chk("wr_reload_addr", 512'(cmd_addr), 512'(4));
        chk("wr_reload_data", wdata, {64{8'h5A}});
        chk("wr_reload_valid", 512'(cmd_valid), 512'(1));
        tick();
        #1;
        chk("wr_done", 512'(cmd_valid), 512'(0));
        chk("wr_no_resp", 512'(resp.valid), 512'(0));
        chk("wr_no_inflight", 512'(rd_inflight), 512'(0));

        // Credits exhausted, then a simultaneous push and pop frees one; 17 responses in order.
        for (int k = 0; k < 17; k++) send_read(64'(100 + k) << 6);
        #1;
        chk("full_inflight16", 512'(rd_inflight), 512'(16));
        chk("full_cmd_blocked", 512'(cmd_valid), 512'(0));
        chk("full_grant_low", 512'(grant), 512'(0));
        for (int k = 0; k < 15; k++) return_data(pat(100 + k));
        #1;
        chk("full_inflight1", 512'(rd_inflight), 512'(1));
        chk("full_still_blocked", 512'(cmd_valid), 512'(0));
        rdata_valid = 1'b1;
        rdata       = pat(115);
        resp_grant  = 1'b1;
        #1;
        chk("pushpop_head", resp.data, pat(100));
        tick();
        rdata_valid = 1'b0;
        resp_grant  = 1'b0;
        #1;
        chk("pushpop_inflight", 512'(rd_inflight), 512'(0));
        chk("pushpop_cmd_valid", 512'(cmd_valid), 512'(1));
        chk("pushpop_cmd_addr", 512'(cmd_addr), 512'(116));
        tick();
        #1;
        chk("read17_inflight", 512'(rd_inflight), 512'(1));
        return_data(pat(116));
        resp_grant = 1'b1;
        for (int k = 101; k <= 116; k++) begin
            #1;
            chk("full_order_valid", 512'(resp.valid), 512'(1));
            chk("full_order_data", resp.data, pat(k));
            tick();
        end
        resp_grant = 1'b0;
        #1;
        chk("full_drained", 512'(resp.valid), 512'(0));

        // Read data with nothing in flight is dropped and flagged.
        rdata_valid = 1'b1;
        rdata       = pat(7);
        tick();
        rdata_valid = 1'b0;
        #1;
        chk("spur_err", 512'(err_spurious), 512'(1));
        chk("spur_no_resp", 512'(resp.valid), 512'(0));
        chk("spur_inflight", 512'(rd_inflight), 512'(0));

        // Reset mid-burst: 8 in flight, 4 buffered.
        for (int k = 0; k < 12; k++) send_read(64'(200 + k) << 6);
        tick();
        for (int k = 0; k < 4; k++) return_data(pat(200 + k));
        #1;
        chk("pre_rst_inflight", 512'(rd_inflight), 512'(8));
        chk("pre_rst_resp", 512'(resp.valid), 512'(1));
        req.valid = 1'b1;
        rst       = 1'b0;
        #1;
        chk("mid_rst_grant", 512'(grant), 512'(0));
        chk("mid_rst_resp_valid", 512'(resp.valid), 512'(0));
        chk("mid_rst_resp_data", resp.data, 512'(0));
        chk("mid_rst_cmd", 512'({cmd_valid, cmd_write, cmd_addr}), 512'(0));
        chk("mid_rst_wdata", wdata, 512'(0));
        chk("mid_rst_inflight", 512'(rd_inflight), 512'(0));
        chk("mid_rst_errs", 512'({err_size, err_spurious}), 512'(0));
        req.valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        do_txn(post);
        chk("post_rst_spur", 512'(err_spurious), 512'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
